// File: rtl/axis_sa_sched_pkg.sv
// Shared types and constants for the axis_sa tile sequencer.
package axis_sa_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned READ_LAT   = 1;

endpackage

// File: rtl/axis_sa_sched_if.sv
// AXI-stream beat bus between the sequencer and the axis_sa array input.
interface axis_sa_sched_if #(
    parameter int unsigned R  = 2,
    parameter int unsigned C  = 2,
    parameter int unsigned WX = 8,
    parameter int unsigned WK = 4
) ();
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic [R*WX-1:0] sx_data;
    logic [C*WK-1:0] sk_data;

    modport master (output s_valid, output s_last, output sx_data, output sk_data, input s_ready);
    modport slave  (input s_valid, input s_last, input sx_data, input sk_data, output s_ready);
endinterface

// File: rtl/axis_sa_sched_skid.sv
// Two-entry FIFO holding {last, data} between the buffer reads and the stream.
module sa_sched_skid
    import axis_sa_sched_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   level
);
    logic [W:0] mem [FIFO_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_last, out_data} = mem[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_last, in_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/axis_sa_sched.sv
// Tile sequencer: reads X/K buffers, streams tiles into axis_sa, counts output
// tiles and limits how many tiles may be in flight.
module axis_sa_sched
    import axis_sa_sched_pkg::*;
#(
    parameter int unsigned R       = 2,
    parameter int unsigned C       = 2,
    parameter int unsigned WX      = 8,
    parameter int unsigned WK      = 4,
    parameter int unsigned AW      = 10,
    parameter int unsigned WKL     = 8,
    parameter int unsigned WT      = 8,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [WKL-1:0]  cfg_k,
    input  logic [WT-1:0]   cfg_tiles,
    input  logic            cfg_reuse_k,
    output logic            busy,
    output logic            done,
    output logic            x_rd_en,
    output logic [AW-1:0]   x_rd_addr,
    input  logic [R*WX-1:0] x_rd_data,
    output logic            k_rd_en,
    output logic [AW-1:0]   k_rd_addr,
    input  logic [C*WK-1:0] k_rd_data,
    axis_sa_sched_if.master s,
    input  logic            m_valid,
    input  logic            m_ready,
    input  logic            m_last
);
    localparam int unsigned W = R*WX + C*WK;

    state_t              state, state_nxt;
    logic [WKL-1:0]      k_q, beat, k_cur;
    logic [WT-1:0]       tiles_q, tile, issued, out_tiles, out_nxt, tiles_cur;
    logic                reuse_q, reuse_cur;
    logic [AW-1:0]       x_addr, k_addr;
    logic [READ_LAT-1:0] rd_vld_pipe, rd_last_pipe;
    logic [1:0]          level;
    logic                fifo_in_ready, pop, m_hs;
    logic                launch, room, first_ok, issue, beat_last, tile_last;
    logic [W-1:0]        head_data;

    // The first read goes out in the start cycle itself, so the live config
    // inputs are used while IDLE and the latched copy afterwards.
    assign launch    = (state == IDLE) && start && (cfg_tiles != '0);
    assign k_cur     = (state == IDLE) ? ((cfg_k == '0) ? WKL'(1) : cfg_k) : k_q;
    assign tiles_cur = (state == IDLE) ? cfg_tiles : tiles_q;
    assign reuse_cur = (state == IDLE) ? cfg_reuse_k : reuse_q;

    assign pop       = s.s_valid & s.s_ready;
    assign m_hs      = (state != IDLE) && m_valid && m_ready && m_last;
    assign out_nxt   = out_tiles + WT'(m_hs);
    assign beat_last = (beat == k_cur - WKL'(1));
    assign tile_last = (tile == tiles_cur - WT'(1));

    // Credit counts the entry leaving this cycle so a full-rate stream keeps going.
    assign room = ((3'(level) + 3'($countones(rd_vld_pipe)) - 3'(pop)) < 3'(FIFO_DEPTH)) && fifo_in_ready;
    assign first_ok = (beat != '0) || ((issued - out_tiles) < WT'(MAX_OUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_tiles == '0)                  state_nxt = DONE;
                    else if (issue && beat_last && tile_last) state_nxt = DRAIN;
                    else                                  state_nxt = ISSUE;
                end
            end
            ISSUE: if (issue && beat_last && tile_last) state_nxt = DRAIN;
            DRAIN: if ((out_nxt == tiles_q) && (level == '0) && (rd_vld_pipe == '0)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        issue   = ((state == ISSUE) || launch) && room && first_ok;
        x_rd_en = issue;
        k_rd_en = issue;
    end

    assign x_rd_addr = x_addr;
    assign k_rd_addr = k_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q          <= '0;
            tiles_q      <= '0;
            reuse_q      <= 1'b0;
            beat         <= '0;
            tile         <= '0;
            issued       <= '0;
            out_tiles    <= '0;
            x_addr       <= '0;
            k_addr       <= '0;
            rd_vld_pipe  <= '0;
            rd_last_pipe <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                k_q     <= (cfg_k == '0) ? WKL'(1) : cfg_k;
                tiles_q <= cfg_tiles;
                reuse_q <= cfg_reuse_k;
            end
            rd_vld_pipe  <= READ_LAT'({rd_vld_pipe, issue});
            rd_last_pipe <= READ_LAT'({rd_last_pipe, beat_last});
            if (state == DONE) begin
                beat      <= '0;
                tile      <= '0;
                issued    <= '0;
                out_tiles <= '0;
                x_addr    <= '0;
                k_addr    <= '0;
            end else begin
                out_tiles <= out_nxt;
                if (issue) begin
                    x_addr <= x_addr + AW'(1);
                    if (beat == '0) issued <= issued + WT'(1);
                    if (beat_last) begin
                        beat   <= '0;
                        tile   <= tile + WT'(1);
                        k_addr <= reuse_cur ? '0 : k_addr + AW'(1);
                    end else begin
                        beat   <= beat + WKL'(1);
                        k_addr <= k_addr + AW'(1);
                    end
                end
            end
        end
    end

    sa_sched_skid #(.W(W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_vld_pipe[READ_LAT-1]),
        .in_ready  (fifo_in_ready),
        .in_data   ({x_rd_data, k_rd_data}),
        .in_last   (rd_last_pipe[READ_LAT-1]),
        .out_valid (s.s_valid),
        .out_ready (s.s_ready),
        .out_data  (head_data),
        .out_last  (s.s_last),
        .level     (level)
    );

    assign s.sx_data = head_data[W-1:C*WK];
    assign s.sk_data = head_data[C*WK-1:0];
endmodule

// File: tb/tb_axis_sa_sched.sv
// Scoreboard bench for axis_sa_sched: buffer and array models, read/beat queues.
module tb_axis_sa_sched;
    logic        clk = 1'b0;
    logic        rstn, start, cfg_reuse_k;
    logic [7:0]  cfg_k, cfg_tiles;
    logic        busy, done, x_rd_en, k_rd_en;
    logic [9:0]  x_rd_addr, k_rd_addr;
    logic [15:0] x_rd_data;
    logic [7:0]  k_rd_data;
    logic        m_valid, m_ready, m_last;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, pending = 0;
    int m_cnt = 0, last_cnt = 0, done_cnt = 0, done_cyc = 0, last_m_cyc = 0;
    logic [19:0] addr_q[$];
    logic [24:0] beat_q[$];
    logic        hold_pend = 1'b0;
    logic [24:0] held;

    axis_sa_sched_if #(.R(2), .C(2), .WX(8), .WK(4)) s_if ();

    axis_sa_sched #(.R(2), .C(2), .WX(8), .WK(4), .AW(10), .WKL(8), .WT(8), .MAX_OUT(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
        .cfg_reuse_k(cfg_reuse_k), .busy(busy), .done(done),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
        .s(s_if), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] xval(input logic [9:0] a);
        return {a[7:0], a[7:0] ^ 8'h5A};
    endfunction
    function automatic logic [7:0] kval(input logic [9:0] a);
        return a[7:0] ^ {a[3:0], 4'h9};
    endfunction

    // Synchronous-read buffers
    always @(posedge clk) begin
        if (x_rd_en) x_rd_data <= xval(x_rd_addr);
        if (k_rd_en) k_rd_data <= kval(k_rd_addr);
    end

    // Array stand-in: one single-beat output tile per input tile
    assign m_valid = (pending != 0);
    assign m_last  = 1'b1;
    always @(posedge clk) begin
        if (!rstn) pending <= 0;
        else pending <= pending + ((s_if.s_valid && s_if.s_ready && s_if.s_last) ? 1 : 0)
                                - ((m_valid && m_ready) ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            hold_pend = 1'b0;
        end else begin
            if (x_rd_en || k_rd_en) begin
                chk("rd_en_pair", 32'(k_rd_en), 32'(x_rd_en));
                if (addr_q.size() == 0) chk("rd_extra", 32'(1), 32'(0));
                else chk("rd_addr", 32'({x_rd_addr, k_rd_addr}), 32'(addr_q.pop_front()));
            end
            if (hold_pend)
                chk("axis_hold", 32'({s_if.s_valid, s_if.sx_data, s_if.sk_data, s_if.s_last}), 32'({1'b1, held}));
            if (s_if.s_valid && s_if.s_ready) begin
                if (s_if.s_last) last_cnt++;
                if (beat_q.size() == 0) chk("beat_extra", 32'(1), 32'(0));
                else chk("beat", 32'({s_if.sx_data, s_if.sk_data, s_if.s_last}), 32'(beat_q.pop_front()));
            end
            hold_pend = s_if.s_valid && !s_if.s_ready;
            held      = {s_if.sx_data, s_if.sk_data, s_if.s_last};
            if (m_valid && m_ready) begin
                m_cnt++;
                last_m_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, x_rd_en, k_rd_en, s_if.s_valid, s_if.s_last}), 32'(0));
        chk({tag, "_addr"}, 32'({x_rd_addr, k_rd_addr}), 32'(0));
        chk({tag, "_data"}, 32'({s_if.sx_data, s_if.sk_data}), 32'(0));
    endtask

    task automatic push_expect(input int ke, input int tiles, input bit reuse);
        for (int t = 0; t < tiles; t++) begin
            for (int b = 0; b < ke; b++) begin
                int a  = t * ke + b;
                int ka = reuse ? b : a;
                addr_q.push_back({10'(a), 10'(ka)});
                beat_q.push_back({xval(10'(a)), kval(10'(ka)), (b == ke - 1)});
            end
        end
    endtask

    task automatic pulse_start(input int k, input int tiles, input bit reuse, output int sc);
        @(posedge clk); #1;
        start = 1'b1; cfg_k = 8'(k); cfg_tiles = 8'(tiles); cfg_reuse_k = reuse;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0; cfg_k = 8'hA5; cfg_tiles = 8'h5A; cfg_reuse_k = ~reuse;
    endtask

    task automatic run(input int k, input int tiles, input bit reuse, input bit rnd, input bit mhold);
        int ke = (k == 0) ? 1 : k;
        int sc, dbase, mbase, lbase;
        push_expect(ke, tiles, reuse);
        dbase = done_cnt; mbase = m_cnt; lbase = last_cnt;
        if (mhold) m_ready = 1'b0;
        pulse_start(k, tiles, reuse, sc);
        if (tiles > 0) begin
            @(negedge clk); chk("lat_sv_c1", 32'(s_if.s_valid), 32'(0));
            @(negedge clk); chk("lat_sv_c2", 32'(s_if.s_valid), 32'(1));
        end
        if (mhold) begin
            repeat (40) @(posedge clk);
            chk("maxout_reads_left", 32'(addr_q.size()), 32'((tiles - 2) * ke));
            chk("maxout_no_done", 32'(done_cnt - dbase), 32'(0));
            @(posedge clk); #1 m_ready = 1'b1;
        end
        for (int i = 0; i < 4000 && done_cnt == dbase; i++) begin
            @(posedge clk); #1;
            if (rnd) s_if.s_ready = 1'($urandom_range(0, 1));
        end
        s_if.s_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_count", 32'(done_cnt - dbase), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("reads_left", 32'(addr_q.size()), 32'(0));
        chk("beats_left", 32'(beat_q.size()), 32'(0));
        chk("m_tiles", 32'(m_cnt - mbase), 32'(tiles));
        chk("s_last_count", 32'(last_cnt - lbase), 32'(tiles));
        if (tiles == 0) chk("zero_done_cyc", 32'(done_cyc), 32'(sc + 1));
        else chk("done_after_mlast", 32'(done_cyc), 32'(last_m_cyc + 1));
    endtask

    initial begin
        rstn = 1'b1; start = 1'b0; cfg_k = '0; cfg_tiles = '0; cfg_reuse_k = 1'b0;
        m_ready = 1'b1; s_if.s_ready = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 rstn = 1'b1;

        run(6, 1, 1'b0, 1'b0, 1'b0);
        run(3, 3, 1'b1, 1'b0, 1'b0);
        run(4, 4, 1'b0, 1'b1, 1'b0);
        run(2, 4, 1'b0, 1'b0, 1'b1);
        run(5, 0, 1'b0, 1'b0, 1'b0);
        run(0, 2, 1'b0, 1'b0, 1'b0);

        // Abort partway through the second tile, then relaunch from scratch
        begin
            int sc;
            push_expect(4, 3, 1'b0);
            pulse_start(4, 3, 1'b0, sc);
            for (int i = 0; i < 200 && addr_q.size() > 6; i++) @(posedge clk);
            chk("abort_reached_tile2", 32'(addr_q.size() <= 6), 32'(1));
            @(posedge clk); #1 rstn = 1'b0;
            #1 check_reset_outputs("abort");
            addr_q.delete();
            beat_q.delete();
            repeat (2) @(posedge clk);
            @(negedge clk) check_reset_outputs("abort_hold");
            @(posedge clk); #1 rstn = 1'b1;
        end
        run(4, 3, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_sa_sched.md
Name: axis_sa_sched

Overview:
Tile sequencer for the axis_sa systolic array. It reads X rows and K columns from two synchronous-read on-chip buffers and streams cfg_tiles tiles of cfg_k beats each into the array's s_* AXI-stream, asserting s_last on each tile's final beat. It counts output tiles by watching the array's m_* handshake, caps the number of in-flight tiles, and pulses done when every output has drained. It sits between the control CSRs/buffers and axis_sa.

Parameters:
R, 2, SA rows; X word count per beat
C, 2, SA cols; K word count per beat
WX, 8, X word width
WK, 4, K word width
AW, 10, buffer address width
WKL, 8, width of cfg_k (beats per tile)
WT, 8, width of cfg_tiles
MAX_OUT, 2, max tiles issued but not yet fully output

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle launch pulse; ignored unless idle
cfg_k  in  WKL  beats per tile; 0 is treated as 1
cfg_tiles  in  WT  tile count; 0 gives an immediate done
cfg_reuse_k  in  1  1: K address = beat index within tile; 0: K address linear
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all tiles are output
x_rd_en  out  1  X buffer read strobe
x_rd_addr  out  AW  X address
x_rd_data  in  R*WX  X data, valid 1 cycle after x_rd_en
k_rd_en  out  1  K buffer read strobe
k_rd_addr  out  AW  K address
k_rd_data  in  C*WK  K data, valid 1 cycle after k_rd_en
s_valid  out  1  to axis_sa
s_ready  in  1  from axis_sa
s_last  out  1  last beat of tile
sx_data  out  R*WX  X beat
sk_data  out  C*WK  K beat
m_valid  in  1  monitored axis_sa output
m_ready  in  1  monitored downstream ready
m_last  in  1  monitored end of output tile

Behaviour:
- Reset values: busy, done, x_rd_en, k_rd_en, s_valid, s_last = 0. Addresses = 0. Data outputs = 0. Internal state is IDLE and all counters are 0.
- Configuration is latched on start in IDLE. It is held stable internally until the return to IDLE.
- States and transitions:
  - IDLE: on start, go to ISSUE. If cfg_tiles==0, go straight to DONE instead.
  - ISSUE: emit reads. Go to DRAIN once the final beat of the final tile has been read.
  - DRAIN: wait for the output-tile count to reach cfg_tiles and the FIFO to be empty, then go to DONE.
  - DONE: done=1 for one cycle, busy drops with it, then go to IDLE.
- Read issue:
  - x_rd_en and k_rd_en are identical.
  - Issue a read only when FIFO occupancy + reads in flight < 2.
  - At the first beat of a tile, also require issued_tiles - out_tiles < MAX_OUT. Issuance counts from the first beat's read.
- Addressing (AW bits, wrap mod 2^AW):
  - x_rd_addr = t*cfg_k + b, for tile t and beat b.
  - k_rd_addr = b if cfg_reuse_k, else t*cfg_k + b.
  - Addresses are maintained incrementally, with no multiplier.
- Each read carries a last tag (b==cfg_k-1). The tag is delayed 1 cycle alongside the data into a 2-deep FIFO.
- FIFO head drives s_valid, sx_data, sk_data, s_last. A pop happens on s_valid&s_ready.
- No bubbles: with s_ready held high, steady state is 1 beat/cycle. The first s_valid comes 2 cycles after the start pulse.
- AXIS rule: once s_valid is high, s_valid and the data are held until s_ready.
- out_tiles increments on m_valid&m_ready&m_last. It may increment in the same cycle as a tile issue; both counters update with no lost count.
- A start pulse outside IDLE is ignored.
- rstn low mid-operation aborts immediately to reset values. In-flight buffer data is discarded.

Decomposition:
- Package axis_sa_sched_pkg holds:
  - the state enum typedef (IDLE, ISSUE, DRAIN, DONE);
  - the FIFO_DEPTH=2 and READ_LAT=1 constants.
- Sub-module sa_sched_skid is a 2-entry FIFO with data+last payload and valid/ready on both sides.

Test Plan:
- cfg_k=6, cfg_tiles=1, s_ready=1 -> 6 beats with x_rd_addr 0..5; s_last on beat 6 only; done one cycle after the output m_last beat.
- cfg_k=3, cfg_tiles=3, cfg_reuse_k=1 -> x addresses 0..8; k addresses 0,1,2 repeated 3 times; three s_last pulses; single done.
- s_ready toggled randomly at 50%, cfg_k=4, cfg_tiles=4 -> beat order and data match buffer contents; s_valid never drops without a handshake; no beat lost or duplicated.
- MAX_OUT=2, m_ready=0 held, cfg_tiles=4 -> tile 3 first read is not issued until one m_last handshake; done only after 4 m_last.
- cfg_tiles=0 -> done in 2nd cycle after start; no reads issued.
- rstn asserted mid-tile 2, then start reissued -> all outputs are reset values during reset; second run restarts at address 0 and completes normally.
